// File: rtl/alu_seq_nbit_if.sv
// Handshake and operand/result bundle for the sequential ALU.
// The master drives operands and ALUOp; the slave (the ALU) returns the result and flags.
interface alu_seq_nbit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       ALUOp;
    logic [WIDTH-1:0] R2;
    logic [WIDTH-1:0] R3;
    logic             c_in;
    logic             out_valid;
    logic [WIDTH-1:0] R1;
    logic             c_out;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, ALUOp, R2, R3, c_in,
        input  in_ready, out_valid, R1, c_out, zero, neg, ovf, busy
    );

    modport slave (
        input  in_valid, ALUOp, R2, R3, c_in,
        output in_ready, out_valid, R1, c_out, zero, neg, ovf, busy
    );
endinterface

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with a valid/ready input and a shift-add multiplier.
// Single-cycle ops complete on the accepting edge; MUL holds off input for WIDTH cycles.
module alu_seq_nbit #(
    parameter int unsigned WIDTH = 32
) (
    input logic           clk,
    input logic           rst,
    alu_seq_nbit_if.slave bus
);
    localparam int unsigned ShW = $clog2(WIDTH);

    localparam logic [3:0] OpMov  = 4'h0;
    localparam logic [3:0] OpNot  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpAnd  = 4'h5;
    localparam logic [3:0] OpSlt  = 4'h6;
    localparam logic [3:0] OpSltu = 4'h7;
    localparam logic [3:0] OpSll  = 4'h8;
    localparam logic [3:0] OpSrl  = 4'h9;
    localparam logic [3:0] OpSra  = 4'hA;
    localparam logic [3:0] OpMul  = 4'hB;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   r1_q, r1_d;
    logic               c_out_q, c_out_d;
    logic               zero_q, zero_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [ShW-1:0]     cnt_q, cnt_d;

    logic               in_ready;
    logic               accept;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     sub_sum;
    logic [ShW-1:0]     shamt;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [2*WIDTH-1:0] acc_nxt;

    assign in_ready = !rst && (state_q == StIdle);
    assign accept   = bus.in_valid && in_ready;
    assign shamt    = bus.R3[ShW-1:0];

    // SUB as R2 + ~R3 + 1 so the top bit is the no-borrow carry.
    assign add_sum = {1'b0, bus.R2} + {1'b0, bus.R3} + {{WIDTH{1'b0}}, bus.c_in};
    assign sub_sum = {1'b0, bus.R2} + {1'b0, ~bus.R3} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.ALUOp)
            OpMov:  alu_res = bus.R2;
            OpNot:  alu_res = ~bus.R2;
            OpAdd: begin
                alu_res = add_sum[WIDTH-1:0];
                alu_c   = add_sum[WIDTH];
                alu_v   = (bus.R2[WIDTH-1] == bus.R3[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != bus.R2[WIDTH-1]);
            end
            OpSub: begin
                alu_res = sub_sum[WIDTH-1:0];
                alu_c   = sub_sum[WIDTH];
                alu_v   = (bus.R2[WIDTH-1] != bus.R3[WIDTH-1]) &&
                          (sub_sum[WIDTH-1] != bus.R2[WIDTH-1]);
            end
            OpOr:   alu_res = bus.R2 | bus.R3;
            OpAnd:  alu_res = bus.R2 & bus.R3;
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.R2) < $signed(bus.R3))};
            OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (bus.R2 < bus.R3)};
            OpSll:  alu_res = bus.R2 << shamt;
            OpSrl:  alu_res = bus.R2 >> shamt;
            OpSra:  alu_res = $signed(bus.R2) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        c_out_d     = c_out_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (bus.ALUOp == OpMul) begin
                        state_d  = StMul;
                        mcand_d  = {{WIDTH{1'b0}}, bus.R2};
                        mplier_d = bus.R3;
                        acc_d    = '0;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                    end else begin
                        r1_d        = alu_res;
                        c_out_d     = alu_c;
                        ovf_d       = alu_v;
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        out_valid_d = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + ShW'(1);
                if (cnt_q == ShW'(WIDTH - 1)) begin
                    r1_d        = acc_nxt[WIDTH-1:0];
                    c_out_d     = 1'b0;
                    ovf_d       = |acc_nxt[2*WIDTH-1:WIDTH];
                    zero_d      = (acc_nxt[WIDTH-1:0] == '0);
                    neg_d       = acc_nxt[WIDTH-1];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            r1_q        <= '0;
            c_out_q     <= 1'b0;
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            r1_q        <= r1_d;
            c_out_q     <= c_out_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.R1        = r1_q;
    assign bus.c_out     = c_out_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed bench for alu_seq_nbit at WIDTH=32: single-cycle ops, flags, MUL timing,
// reset abort of a MUL and back-to-back throughput.
module tb_alu_seq_nbit;
    localparam int unsigned W = 32;

    localparam logic [3:0] OpMov  = 4'h0;
    localparam logic [3:0] OpNot  = 4'h1;
    localparam logic [3:0] OpAdd  = 4'h2;
    localparam logic [3:0] OpSub  = 4'h3;
    localparam logic [3:0] OpOr   = 4'h4;
    localparam logic [3:0] OpAnd  = 4'h5;
    localparam logic [3:0] OpSlt  = 4'h6;
    localparam logic [3:0] OpSltu = 4'h7;
    localparam logic [3:0] OpSll  = 4'h8;
    localparam logic [3:0] OpSrl  = 4'h9;
    localparam logic [3:0] OpSra  = 4'hA;
    localparam logic [3:0] OpMul  = 4'hB;
    localparam logic [3:0] OpRsv  = 4'hD;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    alu_seq_nbit_if #(.WIDTH(W)) bus ();

    alu_seq_nbit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge with in_ready high; returns one edge later.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        bus.ALUOp    = op;
        bus.R2       = a;
        bus.R3       = b;
        bus.c_in     = ci;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] exp_sum;

        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.ALUOp    = 4'h0;
        bus.R2       = '0;
        bus.R3       = '0;
        bus.c_in     = 1'b0;
        step();
        step();
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_r1", bus.R1, 0);
        chk("rst_zero", bus.zero, 0);
        chk("rst_busy", bus.busy, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", bus.in_ready, 1);

        issue(OpAdd, 32'h7FFF_FFFF, 32'h1, 1'b0);
        chk("add_ovf_valid", bus.out_valid, 1);
        chk("add_ovf_r1", bus.R1, 32'h8000_0000);
        chk("add_ovf_ovf", bus.ovf, 1);
        chk("add_ovf_neg", bus.neg, 1);
        chk("add_ovf_c", bus.c_out, 0);
        issue(OpAdd, 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("add_wrap_r1", bus.R1, 0);
        chk("add_wrap_zero", bus.zero, 1);
        chk("add_wrap_c", bus.c_out, 1);
        chk("add_wrap_ovf", bus.ovf, 0);
        issue(OpAdd, 32'h1, 32'h2, 1'b1);
        chk("add_cin_r1", bus.R1, 32'h4);

        issue(OpSub, 32'h5, 32'h5, 1'b0);
        chk("sub_eq_r1", bus.R1, 0);
        chk("sub_eq_zero", bus.zero, 1);
        chk("sub_eq_c", bus.c_out, 1);
        issue(OpSub, 32'h5, 32'h6, 1'b0);
        chk("sub_lt_r1", bus.R1, 32'hFFFF_FFFF);
        chk("sub_lt_neg", bus.neg, 1);
        chk("sub_lt_c", bus.c_out, 0);

        issue(OpSlt, 32'hFFFF_FFFF, 32'h0, 1'b0);
        chk("slt_a", bus.R1, 1);
        issue(OpSltu, 32'hFFFF_FFFF, 32'h0, 1'b0);
        chk("sltu_a", bus.R1, 0);
        issue(OpSlt, 32'h0, 32'hFFFF_FFFF, 1'b0);
        chk("slt_b", bus.R1, 0);
        issue(OpSltu, 32'h0, 32'hFFFF_FFFF, 1'b0);
        chk("sltu_b", bus.R1, 1);

        issue(OpSra, 32'h8000_0000, 32'h24, 1'b0);
        chk("sra_r1", bus.R1, 32'hF800_0000);
        issue(OpSll, 32'h8000_0000, 32'h24, 1'b0);
        chk("sll_r1", bus.R1, 0);
        issue(OpSrl, 32'h8000_0000, 32'h24, 1'b0);
        chk("srl_r1", bus.R1, 32'h0800_0000);
        chk("srl_c", bus.c_out, 0);
        step();
        chk("hold_valid", bus.out_valid, 0);
        chk("hold_r1", bus.R1, 32'h0800_0000);

        issue(OpMov, 32'h1234_5678, 32'h0, 1'b0);
        chk("mov_r1", bus.R1, 32'h1234_5678);
        issue(OpNot, 32'h1234_5678, 32'h0, 1'b0);
        chk("not_r1", bus.R1, 32'hEDCB_A987);
        issue(OpOr, 32'hF0F0_0000, 32'h0F00_00FF, 1'b0);
        chk("or_r1", bus.R1, 32'hFFF0_00FF);
        issue(OpAnd, 32'hF0F0_FFFF, 32'h0FF0_00FF, 1'b0);
        chk("and_r1", bus.R1, 32'h00F0_00FF);
        issue(OpAdd, 32'h7FFF_FFFF, 32'h1, 1'b0);
        issue(OpRsv, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        chk("rsv_valid", bus.out_valid, 1);
        chk("rsv_r1", bus.R1, 0);
        chk("rsv_zero", bus.zero, 1);
        chk("rsv_ovf", bus.ovf, 0);
        chk("rsv_neg", bus.neg, 0);

        // MUL with overflow; pokes on in_valid during the multiply must be ignored.
        issue(OpMul, 32'h0001_0000, 32'h0001_0000, 1'b0);
        for (int k = 1; k <= int'(W); k++) begin
            chk("mul1_busy_valid", bus.out_valid, 0);
            chk("mul1_busy_ready", bus.in_ready, 0);
            chk("mul1_busy_busy", bus.busy, 1);
            bus.in_valid = k[0];
            bus.ALUOp    = OpAdd;
            bus.R2       = k;
            bus.R3       = k;
            step();
        end
        bus.in_valid = 1'b0;
        chk("mul1_valid", bus.out_valid, 1);
        chk("mul1_r1", bus.R1, 0);
        chk("mul1_zero", bus.zero, 1);
        chk("mul1_ovf", bus.ovf, 1);
        chk("mul1_c", bus.c_out, 0);
        chk("mul1_ready", bus.in_ready, 1);
        chk("mul1_busy_done", bus.busy, 0);

        issue(OpMul, 32'd1234, 32'd5678, 1'b0);
        repeat (W) step();
        chk("mul2_valid", bus.out_valid, 1);
        chk("mul2_r1", bus.R1, 32'd7006652);
        chk("mul2_ovf", bus.ovf, 0);
        chk("mul2_ready", bus.in_ready, 1);
        issue(OpAdd, 32'd100, 32'd23, 1'b0);
        chk("add_after_mul_valid", bus.out_valid, 1);
        chk("add_after_mul_r1", bus.R1, 32'd123);
        step();
        chk("add_after_mul_once", bus.out_valid, 0);

        // Reset 10 cycles into a MUL aborts it silently.
        issue(OpMul, 32'd1234, 32'd5678, 1'b0);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("abort_ready", bus.in_ready, 1);
        chk("abort_r1", bus.R1, 0);
        chk("abort_zero", bus.zero, 0);
        chk("abort_busy", bus.busy, 0);
        for (int k = 0; k < int'(W); k++) begin
            chk("abort_no_valid", bus.out_valid, 0);
            step();
        end

        bus.in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a       = 32'h1000_0000 * i + i;
            b       = 32'h3 * i + 32'hFFFF_FFF0;
            ci      = i[0];
            exp_sum = a + b + {31'b0, ci};
            bus.ALUOp = OpAdd;
            bus.R2    = a;
            bus.R3    = b;
            bus.c_in  = ci;
            step();
            chk("b2b_valid", bus.out_valid, 1);
            chk("b2b_r1", bus.R1, exp_sum);
        end
        bus.in_valid = 1'b0;
        step();
        chk("b2b_end_valid", bus.out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
